// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_controller
//  Brief    : Multicycle Moore control FSM for the register-file / shifter /
//             16-bit ALU datapath (MOV imm, MOV reg, ADD, CMP, AND, MVN).
//  Revision : 1.0
// ============================================================================

module cpu_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       asel,
    output logic       bsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic [1:0] alu_op
);

    localparam logic [2:0] c_S_WAIT      = 3'd0;
    localparam logic [2:0] c_S_DECODE    = 3'd1;
    localparam logic [2:0] c_S_WRITE_IMM = 3'd2;
    localparam logic [2:0] c_S_GET_A     = 3'd3;
    localparam logic [2:0] c_S_GET_B     = 3'd4;
    localparam logic [2:0] c_S_COMPUTE   = 3'd5;
    localparam logic [2:0] c_S_WRITE_REG = 3'd6;

    localparam logic [2:0] c_OPC_MOVE = 3'b110;
    localparam logic [2:0] c_OPC_ALU  = 3'b101;

    localparam logic [2:0] c_NSEL_NONE = 3'b000;
    localparam logic [2:0] c_NSEL_RN   = 3'b001;
    localparam logic [2:0] c_NSEL_RD   = 3'b010;
    localparam logic [2:0] c_NSEL_RM   = 3'b100;

    localparam logic [1:0] c_VSEL_C    = 2'b00;
    localparam logic [1:0] c_VSEL_IMM  = 2'b10;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [2:0] r_opcode;
    logic [1:0] r_op;

    logic       w_is_mov_imm;
    logic       w_is_mov_reg;
    logic       w_is_mvn;
    logic       w_is_cmp;
    logic       w_is_two_operand;
    logic       w_zero_a;

    // Instruction-class decode always works from the captured copy.
    assign w_is_mov_imm     = (r_opcode == c_OPC_MOVE) && (r_op == 2'b10);
    assign w_is_mov_reg     = (r_opcode == c_OPC_MOVE) && (r_op == 2'b00);
    assign w_is_mvn         = (r_opcode == c_OPC_ALU)  && (r_op == 2'b11);
    assign w_is_cmp         = (r_opcode == c_OPC_ALU)  && (r_op == 2'b01);
    assign w_is_two_operand = (r_opcode == c_OPC_ALU)  && (r_op != 2'b11);
    assign w_zero_a         = w_is_mov_reg || w_is_mvn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_WAIT;
            r_opcode <= 3'b000;
            r_op     <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if ((r_state == c_S_WAIT) && s) begin
                r_opcode <= opcode;
                r_op     <= op;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_WAIT: begin
                if (s) begin
                    w_state_next = c_S_DECODE;
                end
            end
            c_S_DECODE: begin
                if (w_is_mov_imm) begin
                    w_state_next = c_S_WRITE_IMM;
                end else if (w_is_mov_reg || w_is_mvn) begin
                    w_state_next = c_S_GET_B;
                end else if (w_is_two_operand) begin
                    w_state_next = c_S_GET_A;
                end else begin
                    w_state_next = c_S_WAIT;
                end
            end
            c_S_WRITE_IMM: w_state_next = c_S_WAIT;
            c_S_GET_A:     w_state_next = c_S_GET_B;
            c_S_GET_B:     w_state_next = c_S_COMPUTE;
            c_S_COMPUTE: begin
                if (w_is_cmp) begin
                    w_state_next = c_S_WAIT;
                end else begin
                    w_state_next = c_S_WRITE_REG;
                end
            end
            c_S_WRITE_REG: w_state_next = c_S_WAIT;
            default:       w_state_next = c_S_WAIT;
        endcase
    end

    // Moore outputs: a function of state and the captured instruction only.
    always_comb begin
        w      = 1'b0;
        nsel   = c_NSEL_NONE;
        vsel   = c_VSEL_C;
        asel   = 1'b0;
        bsel   = 1'b0;
        loada  = 1'b0;
        loadb  = 1'b0;
        loadc  = 1'b0;
        loads  = 1'b0;
        write  = 1'b0;
        alu_op = c_ALU_ADD;
        case (r_state)
            c_S_WAIT: begin
                w = 1'b1;
            end
            c_S_WRITE_IMM: begin
                nsel  = c_NSEL_RN;
                vsel  = c_VSEL_IMM;
                write = 1'b1;
            end
            c_S_GET_A: begin
                nsel  = c_NSEL_RN;
                loada = 1'b1;
            end
            c_S_GET_B: begin
                nsel  = c_NSEL_RM;
                loadb = 1'b1;
            end
            c_S_COMPUTE: begin
                asel   = w_zero_a;
                alu_op = w_is_mov_reg ? c_ALU_ADD : r_op;
                loads  = w_is_cmp;
                loadc  = !w_is_cmp;
            end
            c_S_WRITE_REG: begin
                nsel  = c_NSEL_RD;
                vsel  = c_VSEL_C;
                write = 1'b1;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/cpu_controller.md
# cpu_controller

Multicycle Moore control FSM that sequences the register-file / shifter / 16-bit ALU datapath of the RISC machine. It accepts a decoded instruction class (opcode, op) on a start/wait handshake and drives the register-file, pipeline-register, mux and ALU-op controls cycle by cycle until the instruction has retired. Supported instructions:

- MOV Rn,#imm8
- MOV Rd,Rm
- ADD
- CMP
- AND
- MVN

## Interface
Parameters:
- none; the state encoding is internal and free.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s  in  1  start; sampled only in WAIT.
- opcode  in  3  instruction class: 110 = move, 101 = ALU.
- op  in  2  sub-operation.
- w  out  1  idle/ready; high only in WAIT.
- nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm; 000 when unused.
- vsel  out  2  write-back source: 00 datapath C, 10 sign-extended imm8; 01 and 11 are reserved, never driven.
- asel  out  1  1 forces the ALU A input to 16'h0000.
- bsel  out  1  0 in all states; reserved for the imm5 path.
- loada, loadb, loadc, loads  out  1  load enables for the A, B, C and status (Z,N,V) registers.
- write  out  1  register-file write enable.
- alu_op  out  2  ALU function: 00 add, 01 sub, 10 and, 11 not B.

## Operation
- opcode and op are captured into internal registers when s=1 in WAIT. All later decoding uses the captured copy, so upstream may change the inputs after acceptance.
- Outputs are a pure function of state plus the captured opcode/op. No output depends combinationally on s.
- Unless a state below sets a signal, it is 0 (nsel=000, vsel=00, alu_op=00).

States and transitions:
- WAIT: w=1. s=1 -> DECODE; otherwise stay.
- DECODE: all strobes 0.
  - 110/10 -> WRITE_IMM.
  - 110/00 and 101/11 -> GET_B.
  - 101/00, 101/01, 101/10 -> GET_A.
  - Any other combination (illegal) -> WAIT, with no load or write issued.
- WRITE_IMM: nsel=001, vsel=10, write=1 -> WAIT.
- GET_A: nsel=001, loada=1 -> GET_B.
- GET_B: nsel=100, loadb=1 -> COMPUTE.
- COMPUTE: asel=1 for MOV-reg and MVN, else 0.
  - alu_op = 00 for MOV-reg, else the captured op.
  - CMP: loads=1, loadc=0 -> WAIT.
  - Others: loadc=1, loads=0 -> WRITE_REG.
- WRITE_REG: nsel=010, vsel=00, write=1 -> WAIT.

Reset:
- rst_n=0 forces WAIT asynchronously, from any state including mid-instruction.
- Reset values: w=1, all load enables 0, write=0, nsel=000, vsel=00, asel=0, bsel=0, alu_op=00, captured opcode/op = 0.
- A write in progress is cancelled immediately; no partial write-back completes after reset.

Other rules:
- s is ignored outside WAIT. Holding s=1 continuously starts a new instruction on the first WAIT cycle after retirement.
- Only CMP updates the status register.

## Timing
Cycles from the clk edge that samples s=1 in WAIT until w is high again:
- MOV imm: 2 (DECODE, WRITE_IMM).
- Illegal: 1 (DECODE).
- MOV reg, MVN: 3 (DECODE, GET_B, COMPUTE) plus WRITE_REG = 4.
- CMP: 4 (DECODE, GET_A, GET_B, COMPUTE).
- ADD, AND: 5.

Other timing rules:
- w deasserts the cycle after acceptance.
- Minimum spacing between back-to-back instructions is one WAIT cycle.
- Each strobe is high for exactly one cycle per instruction. write and loadc are never both high in the same cycle.

## Test plan
- Reset mid-ADD: drop rst_n during GET_B -> w=1 and all strobes 0 before the next clk edge, with no write pulse. After rst_n rises, state is WAIT.
- MOV imm: opcode=110, op=10, s=1 for one cycle -> WRITE_IMM shows nsel=001, vsel=10, write=1; w high 2 cycles after acceptance; no loada/loadb.
- ADD: opcode=101, op=00 -> loada (nsel=001), then loadb (nsel=100), then loadc with alu_op=00 and asel=0, then write (nsel=010, vsel=00). w returns after 5 cycles; loads never asserted.
- CMP: opcode=101, op=01 -> COMPUTE has loads=1, alu_op=01, loadc=0; write never asserted; w after 4 cycles.
- MVN and MOV reg: op=11 gives alu_op=11, asel=1, GET_A skipped, 4 cycles. 110/00 gives alu_op=00, asel=1.
- Capture and illegal:
  - Change opcode/op and pulse s mid-instruction -> the running sequence is unaffected.
  - opcode=111 -> back to WAIT after 1 cycle with zero strobes.
  - s held high -> the next instruction starts immediately after one WAIT cycle.
